// File: rtl/dec_scan.sv
// Registered one-hot decoder with a prescaled auto-scan sequencer.
// Optional anti-ghosting blanking is enabled by defining DEC_SCAN_BLANK_EN.
module dec_scan #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [DIV_W-1:0]       div,
    output logic [(1<<SEL_W)-1:0]  out,
    output logic [SEL_W-1:0]       idx,
    output logic                   tick,
    output logic                   wrap
);

    localparam int unsigned NOUT = 1 << SEL_W;

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [NOUT-1:0]  out_q, out_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    // Index and prescaler update; disabled cycles hold idx/cnt.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (en) begin
            if (!mode) begin
                idx_d = sel;
                cnt_d = '0;
            end else if (cnt_q >= div) begin
                // >= rather than == so a shrinking div can never overrun the counter
                cnt_d  = '0;
                idx_d  = idx_q + SEL_W'(1);
                tick_d = 1'b1;
                wrap_d = (idx_q == {SEL_W{1'b1}});
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        out_d = '0;
        if (en) begin
            out_d[idx_d] = 1'b1;
`ifdef DEC_SCAN_BLANK_EN
            if (idx_d != idx_q) begin
                out_d = '0;
            end
`endif
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan (SEL_W=3, DIV_W=16).
module tb_dec_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [15:0] div;
    logic [7:0]  out;
    logic [2:0]  idx;
    logic        tick;
    logic        wrap;

    int vectors;
    int miscompares;

    dec_scan #(
        .SEL_W(3),
        .DIV_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .mode(mode),
        .sel (sel),
        .div (div),
        .out (out),
        .idx (idx),
        .tick(tick),
        .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected out for index i; changed = idx moved on this edge.
    function automatic logic [7:0] exp_out(input int i, input bit changed);
        logic [7:0] v;
        v = 8'd1 << i;
`ifdef DEC_SCAN_BLANK_EN
        if (changed) v = 8'd0;
`endif
        return v;
    endfunction

    task automatic chk_idx(input string name, input int exp);
        vectors++;
        if (idx !== 3'(exp)) begin
            miscompares++;
            $display("FAIL %s idx: got %0d expected %0d", name, idx, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] exp);
        vectors++;
        if (out !== exp) begin
            miscompares++;
            $display("FAIL %s out: got %b expected %b", name, out, exp);
        end
    endtask

    task automatic chk_pulse(input string name, input bit et, input bit ew);
        vectors++;
        if (tick !== et || wrap !== ew) begin
            miscompares++;
            $display("FAIL %s tick/wrap: got %b/%b expected %b/%b", name, tick, wrap, et, ew);
        end
    endtask

    // Park in direct mode at index s with cnt cleared.
    task automatic go_direct(input int s);
        rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'(s);
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 3'd5; div = 16'd0;
        step();
        step();
        chk_idx("reset", 0);
        chk_out("reset", 8'h00);
        chk_pulse("reset", 1'b0, 1'b0);
    endtask

    task automatic test_direct();
        rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd5;
        step();
        chk_idx("direct5", 5);
        chk_out("direct5", exp_out(5, 1'b1));
        chk_pulse("direct5", 1'b0, 1'b0);
        step();
        chk_out("direct5_hold", 8'b0010_0000);
        sel = 3'd7;
        step();
        step();
        chk_out("direct7", 8'h80);
        sel = 3'd0;
        step();
        step();
        chk_idx("direct0", 0);
        chk_out("direct0", 8'h01);
        en = 1'b0; sel = 3'd3;
        step();
        chk_idx("direct_en0", 0);
        chk_out("direct_en0", 8'h00);
    endtask

    task automatic test_scan();
        int ei;
        bit t;
        go_direct(0);
        mode = 1'b1; div = 16'd3;
        for (int c = 1; c <= 33; c++) begin
            step();
            ei = (c / 4) % 8;
            t  = (c % 4 == 0);
            chk_idx($sformatf("scan_c%0d", c), ei);
            chk_out($sformatf("scan_c%0d", c), exp_out(ei, t));
            chk_pulse($sformatf("scan_c%0d", c), t, (c == 32));
        end
    endtask

    task automatic test_freeze();
        go_direct(2);
        mode = 1'b1; div = 16'd3;
        step();
        step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_idx("freeze", 2);
            chk_out("freeze", 8'h00);
            chk_pulse("freeze", 1'b0, 1'b0);
        end
        en = 1'b1;
        step();
        chk_idx("freeze_resume1", 2);
        chk_pulse("freeze_resume1", 1'b0, 1'b0);
        step();
        chk_idx("freeze_step", 3);
        chk_out("freeze_step", exp_out(3, 1'b1));
        chk_pulse("freeze_step", 1'b1, 1'b0);
    endtask

    task automatic test_div_shrink();
        go_direct(4);
        mode = 1'b1; div = 16'd100;
        for (int k = 0; k < 50; k++) step();
        chk_idx("shrink_pre", 4);
        chk_pulse("shrink_pre", 1'b0, 1'b0);
        div = 16'd10;
        step();
        chk_idx("shrink_now", 5);
        chk_pulse("shrink_now", 1'b1, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            step();
            chk_idx($sformatf("shrink_k%0d", k), (k == 11) ? 6 : 5);
            chk_pulse($sformatf("shrink_k%0d", k), (k == 11), 1'b0);
        end
    endtask

    task automatic test_div_zero();
        go_direct(6);
        mode = 1'b1; div = 16'd0;
        step();
        chk_idx("div0_a", 7);
        chk_out("div0_a", exp_out(7, 1'b1));
        chk_pulse("div0_a", 1'b1, 1'b0);
        step();
        chk_idx("div0_b", 0);
        chk_pulse("div0_b", 1'b1, 1'b1);
        step();
        chk_idx("div0_c", 1);
        chk_out("div0_c", exp_out(1, 1'b1));
        chk_pulse("div0_c", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        go_direct(2);
        chk_out("b2b_sel2", 8'h04);
        sel = 3'd6;
        step();
        chk_idx("b2b_sel6", 6);
        chk_out("b2b_sel6", exp_out(6, 1'b1));
        step();
        chk_out("b2b_sel6_hold", 8'b0100_0000);
    endtask

    task automatic test_reset_mid_scan();
        go_direct(5);
        mode = 1'b1; div = 16'd3;
        for (int k = 0; k < 4; k++) step();
        chk_idx("midrst_pre", 6);
        rst = 1'b1;
        step();
        chk_idx("midrst_in", 0);
        chk_out("midrst_in", 8'h00);
        chk_pulse("midrst_in", 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_idx("midrst_rel1", 0);
        chk_out("midrst_rel1", 8'h01);
        chk_pulse("midrst_rel1", 1'b0, 1'b0);
        step();
        step();
        chk_idx("midrst_rel3", 0);
        step();
        chk_idx("midrst_rel4", 1);
        chk_pulse("midrst_rel4", 1'b1, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; div = '0;
        #1;
        test_reset();
        test_direct();
        test_scan();
        test_freeze();
        test_div_shrink();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
